// File: rtl/cpu_fetch_pkg.sv
// Shared fetch/decode types: instruction-buffer entry, NOP encoding, default buffer depth.
// Also holds the helper that decides how many entries a fetch group produces.
package cpu_fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ib_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          IB_DEPTH  = 8;

    // A group straddling an 8-byte line, or one that faulted, yields only its first entry.
    function automatic logic [1:0] groupPushCount(input logic cnt2, input logic pc2, input logic adel);
        logic [1:0] n;
        if (cnt2 && !pc2 && !adel) begin
            n = 2'd2;
        end else begin
            n = 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the instruction buffer.
// master = the surrounding pipeline (fetch + decode), slave = the buffer itself.
interface inst_fetch_buffer_if;

    logic        in_valid;
    logic        in_cnt2;
    logic [31:0] in_pc;
    logic [31:0] in_instr0;
    logic [31:0] in_instr1;
    logic        in_adel;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_adel;
    logic        out_ready;

    modport master (
        output in_valid, in_cnt2, in_pc, in_instr0, in_instr1, in_adel, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_adel
    );

    modport slave (
        input  in_valid, in_cnt2, in_pc, in_instr0, in_instr1, in_adel, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_adel
    );

endinterface

// File: rtl/ib_storage.sv
// Instruction-buffer register file: two write ports (one fetch group), one asynchronous read port.
// The two write addresses of a group are always distinct because DEPTH >= 4.
module ib_storage
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we0,
    input  logic [PTR_W-1:0] waddr0,
    input  ib_entry_t        wdata0,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr1,
    input  ib_entry_t        wdata1,
    input  logic [PTR_W-1:0] raddr,
    output ib_entry_t        rdata
);

    ib_entry_t mem_r [DEPTH];

    // Entry array: cleared on reset, written by up to two ports per cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(ib_entry_t){1'b0}};
            end
        end else begin
            if (we0) begin
                mem_r[waddr0] <= wdata0;
            end
            if (we1) begin
                mem_r[waddr1] <= wdata1;
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction buffer between I-cache fetch and decode: takes 1-2 instructions per cycle,
// issues one per cycle with PC and fetch-exception tag; flush drops everything.
module inst_fetch_buffer
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    inst_fetch_buffer_if.slave  ib
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rdPtr_r;
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W:0]   count_r;
    logic             inReady_r;
    logic             outValid_r;

    logic             pushEn_s;
    logic             popEn_s;
    logic [1:0]       pushN_s;
    logic [PTR_W:0]   countNext_s;
    logic [PTR_W-1:0] rdPtrNext_s;
    logic [PTR_W-1:0] wrPtrNext_s;
    ib_entry_t        wdata0_s;
    ib_entry_t        wdata1_s;
    ib_entry_t        head_s;

    assign pushEn_s = ib.in_valid & inReady_r;
    assign popEn_s  = outValid_r & ib.out_ready;

    // Entries produced by this cycle's push (0 when no push happens).
    always_comb begin
        pushN_s = 2'd0;
        if (pushEn_s) begin
            pushN_s = groupPushCount(ib.in_cnt2, ib.in_pc[2], ib.in_adel);
        end else begin
            pushN_s = 2'd0;
        end
    end

    // Next pointer/count state; flush wins over any same-cycle push or pop.
    always_comb begin
        countNext_s = count_r;
        rdPtrNext_s = rdPtr_r;
        wrPtrNext_s = wrPtr_r;
        if (flush) begin
            countNext_s = {(PTR_W+1){1'b0}};
            rdPtrNext_s = {PTR_W{1'b0}};
            wrPtrNext_s = {PTR_W{1'b0}};
        end else begin
            countNext_s = count_r + {{(PTR_W-1){1'b0}}, pushN_s} - {{PTR_W{1'b0}}, popEn_s};
            rdPtrNext_s = rdPtr_r + {{(PTR_W-1){1'b0}}, popEn_s};
            wrPtrNext_s = wrPtr_r + PTR_W'(pushN_s);
        end
    end

    // Pointer, occupancy and registered handshake flags (in_ready never sees out_ready combinationally).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdPtr_r    <= {PTR_W{1'b0}};
            wrPtr_r    <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            inReady_r  <= 1'b1;
            outValid_r <= 1'b0;
        end else begin
            rdPtr_r    <= rdPtrNext_s;
            wrPtr_r    <= wrPtrNext_s;
            count_r    <= countNext_s;
            inReady_r  <= (countNext_s <= (PTR_W+1)'(DEPTH - 2));
            outValid_r <= (countNext_s != {(PTR_W+1){1'b0}});
        end
    end

    assign wdata0_s = '{pc: ib.in_pc, instr: ib.in_instr0, adel: ib.in_adel};
    assign wdata1_s = '{pc: ib.in_pc + 32'd4, instr: ib.in_instr1, adel: 1'b0};

    ib_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk    (clk),
        .resetn (resetn),
        .we0    (pushEn_s & ~flush),
        .waddr0 (wrPtr_r),
        .wdata0 (wdata0_s),
        .we1    ((pushN_s == 2'd2) & ~flush),
        .waddr1 (wrPtr_r + PTR_W'(1)),
        .wdata1 (wdata1_s),
        .raddr  (rdPtr_r),
        .rdata  (head_s)
    );

    assign ib.in_ready  = inReady_r;
    assign ib.out_valid = outValid_r;

    // Head presentation; an empty buffer shows a clean NOP so decode never raises RI on stale data.
    always_comb begin
        ib.out_instr = NOP_INSTR;
        ib.out_pc    = 32'h0000_0000;
        ib.out_adel  = 1'b0;
        if (outValid_r) begin
            ib.out_instr = head_s.instr;
            ib.out_pc    = head_s.pc;
            ib.out_adel  = head_s.adel;
        end else begin
            ib.out_instr = NOP_INSTR;
            ib.out_pc    = 32'h0000_0000;
            ib.out_adel  = 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: linear steps with hand-computed expectations.
module tb_inst_fetch_buffer;

    logic clk;
    logic resetn;
    logic flush;
    int   total;
    int   bad;

    inst_fetch_buffer_if ifc ();

    inst_fetch_buffer dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .ib     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic c2, input logic [31:0] pc,
                         input logic [31:0] i0, input logic [31:0] i1, input logic ad);
        ifc.in_valid  = v;
        ifc.in_cnt2   = c2;
        ifc.in_pc     = pc;
        ifc.in_instr0 = i0;
        ifc.in_instr1 = i1;
        ifc.in_adel   = ad;
    endtask

    initial begin
        logic [31:0] drainPc [5];
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        flush  = 1'b0;
        ifc.out_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // reset state
        #12;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst_out_instr", ifc.out_instr, 32'h0);
        chk("rst_out_pc", ifc.out_pc, 32'h0);
        chk("rst_out_adel", 32'(ifc.out_adel), 32'd0);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("rst_count", 32'(dut.count_r), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // dual push, popped back to back
        drive(1'b1, 1'b1, 32'hBFC0_0000, 32'h2408_0001, 32'h2409_0002, 1'b0);
        ifc.out_ready = 1'b1;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("dual_valid", 32'(ifc.out_valid), 32'd1);
        chk("dual_pc0", ifc.out_pc, 32'hBFC0_0000);
        chk("dual_instr0", ifc.out_instr, 32'h2408_0001);
        chk("dual_count", 32'(dut.count_r), 32'd2);
        tick();
        chk("dual_pc1", ifc.out_pc, 32'hBFC0_0004);
        chk("dual_instr1", ifc.out_instr, 32'h2409_0002);
        chk("dual_count1", 32'(dut.count_r), 32'd1);
        tick();
        chk("empty_valid", 32'(ifc.out_valid), 32'd0);
        chk("empty_instr_nop", ifc.out_instr, 32'h0);

        // cnt2 group straddling the 8-byte line yields one entry
        ifc.out_ready = 1'b0;
        drive(1'b1, 1'b1, 32'hBFC0_0004, 32'hAAAA_0001, 32'hAAAA_0002, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("straddle_count", 32'(dut.count_r), 32'd1);
        chk("straddle_pc", ifc.out_pc, 32'hBFC0_0004);
        chk("straddle_instr", ifc.out_instr, 32'hAAAA_0001);
        ifc.out_ready = 1'b1;
        tick();
        chk("straddle_drained", 32'(dut.count_r), 32'd0);
        ifc.out_ready = 1'b0;

        // fill to 7 (slots 3..7,0,1); the group at 0x1010 wraps from slot 7 to slot 0
        drive(1'b1, 1'b1, 32'h0000_1000, 32'h1, 32'h2, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_1008, 32'h3, 32'h4, 1'b0);
        tick();
        chk("wrap_wrptr", 32'(dut.wrPtr_r), 32'd7);
        drive(1'b1, 1'b1, 32'h0000_1010, 32'h5, 32'h6, 1'b0);
        tick();
        chk("fill6_count", 32'(dut.count_r), 32'd6);
        chk("fill6_ready", 32'(ifc.in_ready), 32'd1);
        drive(1'b1, 1'b0, 32'h0000_2000, 32'h7, 32'h8, 1'b0);
        tick();
        chk("fill7_count", 32'(dut.count_r), 32'd7);
        chk("fill7_ready", 32'(ifc.in_ready), 32'd0);
        drive(1'b1, 1'b1, 32'h0000_9000, 32'h9, 32'hA, 1'b0);
        tick();
        chk("ignored_count", 32'(dut.count_r), 32'd7);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        ifc.out_ready = 1'b1;
        tick();
        chk("pop7_count", 32'(dut.count_r), 32'd6);
        chk("pop7_ready", 32'(ifc.in_ready), 32'd1);
        chk("pop7_head", ifc.out_pc, 32'h0000_1004);

        // drain across the wrap in PC order
        drainPc[0] = 32'h0000_1008;
        drainPc[1] = 32'h0000_100C;
        drainPc[2] = 32'h0000_1010;
        drainPc[3] = 32'h0000_1014;
        drainPc[4] = 32'h0000_2000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("drain_pc%0d", i), ifc.out_pc, drainPc[i]);
        end
        tick();
        chk("drain_empty", 32'(ifc.out_valid), 32'd0);
        ifc.out_ready = 1'b0;

        // flush with a simultaneous dual push at count 4
        drive(1'b1, 1'b1, 32'h0000_3000, 32'h1, 32'h2, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_3008, 32'h3, 32'h4, 1'b0);
        tick();
        chk("preflush_count", 32'(dut.count_r), 32'd4);
        flush = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_4000, 32'h5, 32'h6, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_5000, 32'h5555_0001, 32'h5555_0002, 1'b0);
        chk("flush_valid", 32'(ifc.out_valid), 32'd0);
        chk("flush_count", 32'(dut.count_r), 32'd0);
        chk("flush_wrptr", 32'(dut.wrPtr_r), 32'd0);
        chk("flush_ready", 32'(ifc.in_ready), 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("postflush_valid", 32'(ifc.out_valid), 32'd1);
        chk("postflush_pc", ifc.out_pc, 32'h0000_5000);
        chk("postflush_instr", ifc.out_instr, 32'h5555_0001);
        chk("postflush_count", 32'(dut.count_r), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush2_count", 32'(dut.count_r), 32'd0);

        // faulting dual group yields a single adel entry
        drive(1'b1, 1'b1, 32'h0000_6000, 32'h1111_1111, 32'h2222_2222, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("adel_count", 32'(dut.count_r), 32'd1);
        chk("adel_flag", 32'(ifc.out_adel), 32'd1);
        chk("adel_pc", ifc.out_pc, 32'h0000_6000);
        ifc.out_ready = 1'b1;
        tick();
        chk("adel_drained", 32'(dut.count_r), 32'd0);
        chk("adel_clear", 32'(ifc.out_adel), 32'd0);
        ifc.out_ready = 1'b0;

        // asynchronous reset mid-traffic at count 5
        drive(1'b1, 1'b1, 32'h0000_7000, 32'h1, 32'h2, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_7008, 32'h3, 32'h4, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_7010, 32'h5, 32'h6, 1'b0);
        tick();
        chk("pre_reset_count", 32'(dut.count_r), 32'd5);
        drive(1'b1, 1'b1, 32'h0000_7020, 32'h7, 32'h8, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ifc.out_valid), 32'd0);
        chk("async_rst_ready", 32'(ifc.in_ready), 32'd1);
        chk("async_rst_count", 32'(dut.count_r), 32'd0);
        chk("async_rst_pc", ifc.out_pc, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        resetn = 1'b1;
        tick();
        chk("after_rst_count", 32'(dut.count_r), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
